// File: rtl/game_tick_scheduler_if.sv
// rtl/game_tick_scheduler_if.sv - game control inputs and timing strobes/status of the tick scheduler
interface game_tick_scheduler_if;
    logic       start;
    logic       pause;
    logic       hit;
    logic       miss;
    logic       frame_tick;
    logic       paddle_tick;
    logic       ball_tick;
    logic [1:0] state;
    logic [3:0] speed_lvl;
    logic       serving;

    modport master (
        output start, pause, hit, miss,
        input  frame_tick, paddle_tick, ball_tick, state, speed_lvl, serving
    );

    modport slave (
        input  start, pause, hit, miss,
        output frame_tick, paddle_tick, ball_tick, state, speed_lvl, serving
    );
endinterface

// File: rtl/game_tick_scheduler.sv
// rtl/game_tick_scheduler.sv - pong strobe generator and serve/play/pause rally sequencer
module game_tick_scheduler #(
    parameter int FRAME_PERIOD     = 833_333,
    parameter int PADDLE_PERIOD    = 250_000,
    parameter int BALL_PERIOD_INIT = 500_000,
    parameter int BALL_PERIOD_MIN  = 100_000,
    parameter int BALL_PERIOD_STEP = 50_000,
    parameter int SERVE_FRAMES     = 60,
    parameter int CNT_W            = 20
) (
    input  logic                  Clk,
    input  logic                  Rst,
    game_tick_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, PAUSED = 2'd3} state_t;

    localparam int SRV_W = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0] ONE           = CNT_W'(1);
    localparam logic [CNT_W-1:0] FRAME_LAST    = CNT_W'(FRAME_PERIOD - 1);
    localparam logic [CNT_W-1:0] PADDLE_LAST   = CNT_W'(PADDLE_PERIOD - 1);
    localparam logic [CNT_W-1:0] BALL_INIT     = CNT_W'(BALL_PERIOD_INIT);
    localparam logic [CNT_W-1:0] BALL_MIN      = CNT_W'(BALL_PERIOD_MIN);
    localparam logic [CNT_W-1:0] BALL_STEP     = CNT_W'(BALL_PERIOD_STEP);
    localparam logic [CNT_W-1:0] MIN_PLUS_STEP = CNT_W'(BALL_PERIOD_MIN + BALL_PERIOD_STEP);
    localparam logic [SRV_W-1:0] SRV_LOAD      = SRV_W'(SERVE_FRAMES);
    localparam logic [SRV_W-1:0] SRV_ONE       = SRV_W'(1);

    state_t cur, nxt, saved, saved_nxt;
    logic [CNT_W-1:0] frame_cnt, paddle_cnt, ball_cnt, ball_period;
    logic [SRV_W-1:0] serve_cnt;
    logic [3:0]       speed_lvl;
    logic             frame_tick, paddle_tick, ball_tick, serving;
    logic             new_game, rally_reset, serve_dec, speed_up;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cur   <= IDLE;
            saved <= SERVE;
        end else begin
            cur   <= nxt;
            saved <= saved_nxt;
        end
    end

    // A pause always parks the state this cycle would have produced, so a miss or
    // a final serve frame coinciding with pause is resolved before freezing.
    always_comb begin
        nxt         = cur;
        saved_nxt   = saved;
        new_game    = 1'b0;
        rally_reset = 1'b0;
        serve_dec   = 1'b0;
        speed_up    = 1'b0;
        case (cur)
            IDLE: begin
                if (bus.start) begin
                    nxt      = SERVE;
                    new_game = 1'b1;
                end
            end
            SERVE: begin
                if (frame_tick) begin
                    serve_dec = 1'b1;
                    if (serve_cnt <= SRV_ONE) nxt = PLAY;
                end
                if (bus.pause) begin
                    saved_nxt = nxt;
                    nxt       = PAUSED;
                end
            end
            PLAY: begin
                if (bus.miss) begin
                    rally_reset = 1'b1;
                    nxt         = SERVE;
                end else if (bus.hit && !bus.pause) begin
                    speed_up = 1'b1;
                end
                if (bus.pause) begin
                    saved_nxt = nxt;
                    nxt       = PAUSED;
                end
            end
            PAUSED: begin
                if (!bus.pause) nxt = saved;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            frame_cnt   <= '0;
            paddle_cnt  <= '0;
            ball_cnt    <= '0;
            frame_tick  <= 1'b0;
            paddle_tick <= 1'b0;
            ball_tick   <= 1'b0;
            ball_period <= BALL_INIT;
            speed_lvl   <= '0;
            serve_cnt   <= '0;
            serving     <= 1'b0;
        end else begin
            frame_tick <= (frame_cnt >= FRAME_LAST);
            frame_cnt  <= (frame_cnt >= FRAME_LAST) ? '0 : frame_cnt + ONE;

            paddle_tick <= 1'b0;
            if (cur == IDLE) begin
                paddle_cnt <= '0;
            end else if (cur == SERVE || cur == PLAY) begin
                paddle_tick <= (paddle_cnt >= PADDLE_LAST);
                paddle_cnt  <= (paddle_cnt >= PADDLE_LAST) ? '0 : paddle_cnt + ONE;
            end

            // >= against the live period lets a hit shorten the count in flight
            ball_tick <= 1'b0;
            if (rally_reset || cur == IDLE) begin
                ball_cnt <= '0;
            end else if (cur == PLAY) begin
                ball_tick <= (ball_cnt >= ball_period - ONE);
                ball_cnt  <= (ball_cnt >= ball_period - ONE) ? '0 : ball_cnt + ONE;
            end

            if (new_game || rally_reset) begin
                ball_period <= BALL_INIT;
                speed_lvl   <= '0;
                serve_cnt   <= SRV_LOAD;
            end else begin
                if (speed_up && ball_period > BALL_MIN) begin
                    ball_period <= (ball_period > MIN_PLUS_STEP) ? ball_period - BALL_STEP : BALL_MIN;
                    if (speed_lvl != 4'd15) speed_lvl <= speed_lvl + 4'd1;
                end
                if (serve_dec && serve_cnt != '0) serve_cnt <= serve_cnt - SRV_ONE;
            end

            serving <= (nxt == SERVE);
        end
    end

    assign bus.frame_tick  = frame_tick;
    assign bus.paddle_tick = paddle_tick;
    assign bus.ball_tick   = ball_tick;
    assign bus.state       = cur;
    assign bus.speed_lvl   = speed_lvl;
    assign bus.serving     = serving;
endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
Central timing controller for the pong game. It derives single-cycle enable strobes from the one system clock: ball-motion tick, paddle-motion tick and frame tick. It sequences the rally through serve, play and pause, and speeds up the ball on each paddle hit. All game logic runs on Clk and is gated by these strobes. No derived clocks are used.

Parameters:
FRAME_PERIOD, 833_333, Clk cycles per frame_tick (60 Hz at 50 MHz)
PADDLE_PERIOD, 250_000, Clk cycles per paddle_tick
BALL_PERIOD_INIT, 500_000, ball_tick period at serve (speed level 0)
BALL_PERIOD_MIN, 100_000, fastest allowed ball_tick period
BALL_PERIOD_STEP, 50_000, period decrement per accepted hit
SERVE_FRAMES, 60, frame_ticks spent in SERVE before play starts
CNT_W, 20, width of the period counters and registers; must hold every period above

Ports:
Clk  in  1  system clock
Rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begin a game (honoured only in IDLE)
pause  in  1  level; high = freeze play
hit  in  1  one-cycle pulse; ball struck by a paddle
miss  in  1  one-cycle pulse; ball left the field, point scored
frame_tick  out  1  one-cycle strobe every FRAME_PERIOD cycles
paddle_tick  out  1  one-cycle strobe every PADDLE_PERIOD cycles while in SERVE/PLAY
ball_tick  out  1  one-cycle strobe every ball_period cycles while in PLAY
state  out  2  0=IDLE, 1=SERVE, 2=PLAY, 3=PAUSED
speed_lvl  out  4  number of accepted speed-ups since the last serve
serving  out  1  high while state==SERVE

Behaviour:
- Reset (async, any time): state=IDLE, all counters=0, ball_period=BALL_PERIOD_INIT, speed_lvl=0, serve count=0, saved state=SERVE. All tick outputs and serving are 0 immediately.
- All outputs are registered.
- Tick generation: each counter counts up from 0. Its tick is asserted for one cycle after the cycle in which count >= period-1, and the count returns to 0 in that cycle. The >= compare absorbs a ball_period shrink mid-count.
- Tick timing: the first tick comes P cycles after the counter leaves 0.
- Frame counter: free-runs in every state.
- Paddle counter: runs in SERVE and PLAY. It is held (not cleared) in PAUSED and cleared in IDLE.
- Ball counter: runs only in PLAY. It is held in PAUSED and cleared on entry to SERVE.
- IDLE: on start -> SERVE. Load serve count=SERVE_FRAMES, ball_period=INIT, speed_lvl=0.
- SERVE: serve count decrements on each frame_tick. When it reaches 0 the state goes to PLAY (same cycle as the final decrement).
- PLAY, miss -> SERVE: serve count reloaded, ball_period=INIT, speed_lvl=0, ball counter=0.
- PLAY, hit: if ball_period > MIN, set ball_period = max(ball_period-STEP, MIN) and speed_lvl+1. Otherwise there is no change. speed_lvl saturates at 15.
- PAUSE: pause high in SERVE or PLAY saves the current state and goes to PAUSED on the next edge. In PAUSED, hit, miss and start are ignored. pause low -> return to the saved state with counters and serve count intact.
- Priority in one cycle: miss > pause > hit. If miss and pause arrive together, the miss is applied first, the state goes to PAUSED, and the saved state is SERVE.
- start outside IDLE is ignored. There is no return to IDLE except Rst.
- Width: period arithmetic uses CNT_W bits, and the subtraction is done guarded (no underflow wrap).

Test Plan:
Small params for all tests: FRAME=8, PADDLE=5, BALL_INIT=10, MIN=4, STEP=3, SERVE_FRAMES=2.
1. Release Rst and idle 40 cycles -> frame_tick at cycles 8,16,24,32,40. No paddle_tick or ball_tick. state=0, speed_lvl=0.
2. Pulse start -> state=1 and serving=1 next cycle. paddle_tick every 5 cycles. state=2 on the 2nd subsequent frame_tick. Then ball_tick every 10 cycles.
3. In PLAY, pulse hit 3 times, 30 cycles apart -> ball period 7, 4, 4. speed_lvl=1, 2, 2. The ball_tick interval shrinks to 4.
4. In PLAY, hold pause 50 cycles mid ball-count (count=6) -> state=3. No ball_tick or paddle_tick, frame_tick continues. After release: state=2, next ball_tick 4 cycles later (period 10).
5. hit and miss in the same PLAY cycle -> state=1, speed_lvl=0, ball period 10, no ball_tick until the serve completes.
6. Assert Rst asynchronously mid-PLAY with ball_tick high -> all outputs 0 and state=0 before the next Clk edge. start afterwards behaves as in test 2.
